tx_uart: RTL and testbench

UART transmitter. It serialises one parallel byte into an asynchronous frame: one start bit, NB_DATA data bits LSB first, then N_STOP stop bits. Bit timing is paced by the oversampling tick from the baudrate generator, the same tick that drives rx_uart. The block is the transmit half of the UART, and its frames must be received error-free by rx_uart when the two share the same parameters.

---
 rtl/tx_uart.sv | 119 +++++++++++
 tb/tb_tx_uart.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tx_uart.sv
// rtl/tx_uart.sv - UART transmitter: start bit, NB_DATA data bits LSB first, N_STOP stop bits
module tx_uart #(
    parameter int NB_DATA       = 8,
    parameter int N_STOP        = 2,
    parameter int N_TICKS       = 16,
    parameter int NB_COUNT      = 4,
    parameter int NB_DATA_COUNT = 3,
    parameter int NB_STATE      = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_tx_done_tick,
    output logic               o_busy
);

    typedef enum logic [NB_STATE-1:0] {IDLE, START, DATA, STOP} state_t;

    // One extra counter bit lets the stop phase count all N_STOP bits in one run.
    localparam logic [NB_COUNT:0]        LAST_BIT  = (NB_COUNT+1)'(N_TICKS - 1);
    localparam logic [NB_COUNT:0]        LAST_STOP = (NB_COUNT+1)'(N_STOP * N_TICKS - 1);
    localparam logic [NB_COUNT:0]        TICK_ONE  = (NB_COUNT+1)'(1);
    localparam logic [NB_DATA_COUNT-1:0] LAST_DATA = NB_DATA_COUNT'(NB_DATA - 1);
    localparam logic [NB_DATA_COUNT-1:0] BIT_ONE   = NB_DATA_COUNT'(1);

    state_t                   state_q, state_d;
    logic [NB_COUNT:0]        tick_q, tick_d;
    logic [NB_DATA_COUNT-1:0] bit_q, bit_d;
    logic [NB_DATA-1:0]       shift_q, shift_d;
    logic                     tx_q, tx_d;
    logic                     done;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (i_tx_start) begin
                    shift_d = i_data;
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_q == LAST_BIT) begin
                        tick_d  = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tick_q == LAST_BIT) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == LAST_DATA) begin
                            bit_d   = '0;
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (tick_q == LAST_STOP) begin
                        tick_d  = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // The line level is computed from the next state so o_tx is a clean flop output.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign o_tx           = tx_q;
    assign o_tx_done_tick = done;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tx_uart.sv
// tb/tb_tx_uart.sv - directed self-checking bench for tx_uart
module tb_tx_uart;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_done_tick;
    logic       o_busy;

    int n_checks   = 0;
    int n_pass     = 0;
    int done_total = 0;

    always #5 clk = ~clk;

    tx_uart dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_tick        (i_tick),
        .i_tx_start    (i_tx_start),
        .i_data        (i_data),
        .o_tx          (o_tx),
        .o_tx_done_tick(o_tx_done_tick),
        .o_busy        (o_busy)
    );

    always @(posedge clk) if (o_tx_done_tick === 1'b1) done_total <= done_total + 1;

    // Independent receiver: mid-bit sampling, valid while i_tick is high every cycle.
    bit         rx_en   = 1'b0;
    bit         rx_act  = 1'b0;
    int         rx_cnt  = 0;
    int         rx_ferr = 0;
    logic [7:0] rx_sh   = '0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!rx_en) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (o_tx === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt == 8 && o_tx !== 1'b0) begin
                rx_act <= 1'b0;
            end else if (rx_cnt >= 24 && rx_cnt <= 136 && ((rx_cnt - 8) % 16) == 0) begin
                rx_sh <= {o_tx, rx_sh[7:1]};
            end else if (rx_cnt == 152) begin
                rx_act <= 1'b0;
                if (o_tx === 1'b1) rx_q.push_back(rx_sh);
                else rx_ferr <= rx_ferr + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends d with one tick every p cycles and checks every line sample of the frame.
    task automatic run_frame(input logic [7:0] d, input int p, input int perturb_at, input string tag);
        int   total;
        int   mism;
        int   notbusy;
        int   ndone;
        int   done_at;
        int   b;
        logic e;
        total   = 11 * 16 * p;
        mism    = 0;
        notbusy = 0;
        ndone   = 0;
        done_at = -1;
        i_data     = d;
        i_tx_start = 1'b1;
        i_tick     = 1'b0;
        step();
        i_tx_start = 1'b0;
        i_data     = ~d;
        for (int c = 0; c < total; c++) begin
            b      = c / (16 * p);
            i_tick = ((c % p) == (p - 1));
            if (c == perturb_at) begin
                i_tx_start = 1'b1;
                i_data     = 8'hFF;
            end else begin
                i_tx_start = 1'b0;
            end
            #1;
            if (b == 0)      e = 1'b0;
            else if (b <= 8) e = d[b-1];
            else             e = 1'b1;
            if (o_tx !== e) mism++;
            if (o_busy !== 1'b1) notbusy++;
            if (o_tx_done_tick === 1'b1) begin
                ndone++;
                done_at = c;
            end
            step();
        end
        i_tx_start = 1'b0;
        i_tick     = 1'b0;
        chk({tag, " line bits mismatches"}, mism, 0);
        chk({tag, " busy dropouts"}, notbusy, 0);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " done frame cycle"}, done_at + 1, total);
        chk({tag, " idle after"}, {o_busy, o_tx}, 2'b01);
    endtask

    initial begin
        int bad;
        i_reset    = 1'b0;
        i_tx_start = 1'b1;
        i_tick     = 1'b1;
        i_data     = 8'hBD;
        repeat (3) step();
        chk("reset o_tx", o_tx, 1'b1);
        chk("reset o_busy", o_busy, 1'b0);
        chk("reset done", o_tx_done_tick, 1'b0);

        i_tx_start = 1'b0;
        i_reset    = 1'b1;
        bad = 0;
        repeat (20) begin
            step();
            if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
        end
        chk("post-reset idle", bad, 0);
        chk("post-reset done count", done_total, 0);

        run_frame(8'hBD, 1, -1, "frame BD");
        chk("done total after BD", done_total, 1);

        run_frame(8'h00, 4, -1, "sparse 00");

        run_frame(8'hC3, 1, 50, "busy C3");
        bad = 0;
        repeat (40) begin
            step();
            if (o_tx !== 1'b1 || o_busy !== 1'b0) bad++;
        end
        chk("no queued frame", bad, 0);
        chk("done total after busy", done_total, 3);

        rx_en = 1'b1;
        run_frame(8'h55, 1, -1, "b2b 55");
        run_frame(8'hAA, 1, -1, "b2b AA");
        step();
        rx_en = 1'b0;
        chk("rx count", rx_q.size(), 2);
        chk("rx byte0", (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'hDEAD, 32'h55);
        chk("rx byte1", (rx_q.size() > 1) ? {24'h0, rx_q[1]} : 32'hDEAD, 32'hAA);
        chk("rx framing errors", rx_ferr, 0);

        i_data     = 8'hA5;
        i_tx_start = 1'b1;
        step();
        i_tx_start = 1'b0;
        for (int c = 0; c < 70; c++) begin
            i_tick = 1'b1;
            step();
        end
        chk("data bit3 low before reset", o_tx, 1'b0);
        i_reset = 1'b0;
        #1;
        chk("async reset o_tx", o_tx, 1'b1);
        chk("async reset o_busy", o_busy, 1'b0);
        step();
        step();
        i_reset = 1'b1;
        repeat (5) step();
        chk("no done after abort", done_total, 5);

        run_frame(8'h3C, 1, -1, "after reset 3C");
        chk("done total final", done_total, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
